// File: rtl/delay_monitor.sv
// delay_monitor: receive-side checker for the generator's periodic one-cycle sig pulse.
// Optional DELAY_MON_STICKY_EN: error flags hold until reset and the locked output is masked once any error is seen.
module delay_monitor #(
  parameter int N        = 17500,
  parameter int CBITS    = 15,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int FCBITS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig,
  output logic              locked,
  output logic              err_early,
  output logic              err_late,
  output logic [FCBITS-1:0] fault_cnt
);

  localparam int                GBITS = $clog2(LOCK_CNT + 1);
  localparam logic [CBITS-1:0]  LO    = CBITS'(N - TOL);
  localparam logic [CBITS-1:0]  HI    = CBITS'(N + TOL);
  localparam logic [CBITS-1:0]  CMAX  = {CBITS{1'b1}};
  localparam logic [GBITS-1:0]  GLOCK = GBITS'(LOCK_CNT);
  localparam logic [FCBITS-1:0] FMAX  = {FCBITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CBITS-1:0]  cnt_q, cnt_d;
  logic [GBITS-1:0]  good_q, good_d;
  logic [FCBITS-1:0] fault_q, fault_d;
  logic              locked_q, locked_d;
  logic              early_q, early_d;
  logic              late_q, late_d;

  logic              good_s, early_s, late_s;
  logic              new_early_s, new_late_s;
  logic [CBITS-1:0]  next_cnt_s;

  // A pulse exactly at cnt==HI is good; late only fires when no pulse arrives there.
  assign good_s     = sig && (cnt_q >= LO) && (cnt_q <= HI);
  assign early_s    = sig && (cnt_q < LO);
  assign late_s     = !sig && (cnt_q == HI);
  assign next_cnt_s = sig ? {CBITS{1'b0}}
                          : ((cnt_q == CMAX) ? cnt_q : cnt_q + CBITS'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    good_d      = good_q;
    new_early_s = 1'b0;
    new_late_s  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = {CBITS{1'b0}};
        if (sig) begin
          state_d = ACQ;
          good_d  = {GBITS{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ACQ: begin
        cnt_d = next_cnt_s;
        if (good_s) begin
          good_d = good_q + GBITS'(1);
          if ((good_q + GBITS'(1)) == GLOCK) begin
            state_d = LOCKED;
          end else begin
            state_d = ACQ;
          end
        end else if (early_s) begin
          good_d = {GBITS{1'b0}};
        end else if (late_s) begin
          state_d = IDLE;
          cnt_d   = {CBITS{1'b0}};
        end else begin
          good_d = good_q;
        end
      end
      LOCKED: begin
        cnt_d = next_cnt_s;
        if (early_s) begin
          state_d     = ACQ;
          good_d      = {GBITS{1'b0}};
          new_early_s = 1'b1;
        end else if (late_s) begin
          state_d    = IDLE;
          cnt_d      = {CBITS{1'b0}};
          new_late_s = 1'b1;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CBITS{1'b0}};
        good_d  = {GBITS{1'b0}};
      end
    endcase
  end

  always_comb begin
    if ((new_early_s || new_late_s) && (fault_q != FMAX)) begin
      fault_d = fault_q + FCBITS'(1);
    end else begin
      fault_d = fault_q;
    end
`ifdef DELAY_MON_STICKY_EN
    early_d  = early_q | new_early_s;
    late_d   = late_q | new_late_s;
    locked_d = (state_d == LOCKED) && !early_d && !late_d;
`else
    early_d  = new_early_s;
    late_d   = new_late_s;
    locked_d = (state_d == LOCKED);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= {CBITS{1'b0}};
      good_q   <= {GBITS{1'b0}};
      fault_q  <= {FCBITS{1'b0}};
      locked_q <= 1'b0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      fault_q  <= fault_d;
      locked_q <= locked_d;
      early_q  <= early_d;
      late_q   <= late_d;
    end
  end

  assign locked    = locked_q;
  assign err_early = early_q;
  assign err_late  = late_q;
  assign fault_cnt = fault_q;

endmodule

// File: tb/tb_delay_monitor.sv
// Self-checking bench for delay_monitor: directed scenarios plus randomized intervals against an interval-level model.
module tb_delay_monitor;
  localparam int N = 10, TOL = 1, LOCK_CNT = 3, CBITS = 15, FCBITS = 8;
`ifdef DELAY_MON_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sig = 1'b0;
  logic locked, err_early, err_late;
  logic [FCBITS-1:0] fault_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 acquiring, 2 locked; m_since = cycles since reference pulse.
  int m_mode = 0, m_since = 0, m_good = 0, m_fault = 0;
  bit m_locked = 1'b0, m_ee = 1'b0, m_el = 1'b0;

  always #5 clk = ~clk;

  delay_monitor #(.N(N), .CBITS(CBITS), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .FCBITS(FCBITS)) dut (
    .clk(clk), .rst(rst), .sig(sig),
    .locked(locked), .err_early(err_early), .err_late(err_late), .fault_cnt(fault_cnt)
  );

  task automatic model_clk(input logic r, input logic s);
    bit ee, el;
    int iv;
    ee = 1'b0;
    el = 1'b0;
    if (!r) begin
      m_mode = 0; m_since = 0; m_good = 0; m_fault = 0;
      m_locked = 1'b0; m_ee = 1'b0; m_el = 1'b0;
    end else begin
      if (m_mode == 0) begin
        if (s) begin m_mode = 1; m_since = 0; m_good = 0; end
      end else if (s) begin
        iv = m_since + 1;
        m_since = 0;
        if (iv >= N + 1 - TOL && iv <= N + 1 + TOL) begin
          if (m_mode == 1) begin
            m_good++;
            if (m_good == LOCK_CNT) m_mode = 2;
          end
        end else if (iv < N + 1 - TOL) begin
          if (m_mode == 2) ee = 1'b1;
          m_mode = 1;
          m_good = 0;
        end
      end else if (m_since == N + TOL) begin
        if (m_mode == 2) el = 1'b1;
        m_mode = 0;
        m_since = 0;
      end else begin
        m_since++;
      end
      if ((ee || el) && m_fault < 255) m_fault++;
      if (STK) begin
        m_ee = m_ee | ee;
        m_el = m_el | el;
        m_locked = (m_mode == 2) && !m_ee && !m_el;
      end else begin
        m_ee = ee;
        m_el = el;
        m_locked = (m_mode == 2);
      end
    end
  endtask

  task automatic step(input logic r, input logic s);
    rst = r;
    sig = s;
    @(posedge clk);
    model_clk(r, s);
    #1;
  endtask

  // Interval of iv cycles measured from the previous pulse: iv-1 quiet cycles then a pulse.
  task automatic drive_iv(input int iv);
    for (int c = 1; c <= iv; c++) step(1'b1, c == iv);
  endtask

  task automatic acquire_lock();
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int p = 0; p < LOCK_CNT; p++) drive_iv(N + 1);
  endtask

  function automatic logic [FCBITS+2:0] obs_v();
    return {locked, err_early, err_late, fault_cnt};
  endfunction

  function automatic logic [FCBITS+2:0] exp_v();
    return {m_locked, m_ee, m_el, FCBITS'(m_fault)};
  endfunction

  task automatic test_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    n_checks++;
    if (obs_v() !== {(FCBITS+3){1'b0}}) begin
      n_fail++;
      $display("FAIL reset_state got=%h expected=%h", obs_v(), {(FCBITS+3){1'b0}});
    end
  endtask

  task automatic test_basic_lock();
    step(1'b1, 1'b1);
    for (int p = 2; p <= 4; p++) begin
      drive_iv(11);
      n_checks++;
      if (locked !== 1'(p == 4)) begin
        n_fail++;
        $display("FAIL basic_lock pulse=%0d locked=%b expected=%b", p, locked, 1'(p == 4));
      end
    end
    n_checks++;
    if ({err_early, err_late, fault_cnt} !== {2'b00, 8'd0}) begin
      n_fail++;
      $display("FAIL basic_lock_errs got=%b%b fault=%0d expected=00 fault=0", err_early, err_late, fault_cnt);
    end
  endtask

  task automatic test_tolerance();
    drive_iv(10);
    n_checks++;
    if ({locked, err_early, err_late} !== 3'b100) begin
      n_fail++;
      $display("FAIL tol_iv10 got=%b expected=100", {locked, err_early, err_late});
    end
    drive_iv(12);
    n_checks++;
    if ({locked, err_early, err_late} !== 3'b100) begin
      n_fail++;
      $display("FAIL tol_iv12 got=%b expected=100", {locked, err_early, err_late});
    end
    drive_iv(9);
    n_checks++;
    if ({locked, err_early, err_late, fault_cnt} !== {3'b010, 8'd1}) begin
      n_fail++;
      $display("FAIL tol_iv9 got=%b fault=%0d expected=010 fault=1", {locked, err_early, err_late}, fault_cnt);
    end
    step(1'b1, 1'b0);
    n_checks++;
    if (err_early !== STK) begin
      n_fail++;
      $display("FAIL tol_early_width err_early=%b expected=%b", err_early, STK);
    end
    drive_iv(10);
    drive_iv(11);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL tol_relock_early locked=%b expected=0", locked);
    end
    drive_iv(11);
    n_checks++;
    if ({locked, fault_cnt} !== {!STK, 8'd1}) begin
      n_fail++;
      $display("FAIL tol_relock got locked=%b fault=%0d expected locked=%b fault=1", locked, fault_cnt, !STK);
    end
  endtask

  task automatic test_late();
    acquire_lock();
    for (int c = 1; c <= 11; c++) step(1'b1, 1'b0);
    n_checks++;
    if ({locked, err_late} !== 2'b10) begin
      n_fail++;
      $display("FAIL late_before got=%b expected=10", {locked, err_late});
    end
    step(1'b1, 1'b0);
    n_checks++;
    if ({locked, err_early, err_late, fault_cnt} !== {3'b001, 8'd1}) begin
      n_fail++;
      $display("FAIL late_fire got=%b fault=%0d expected=001 fault=1", {locked, err_early, err_late}, fault_cnt);
    end
    step(1'b1, 1'b0);
    n_checks++;
    if (err_late !== STK) begin
      n_fail++;
      $display("FAIL late_width err_late=%b expected=%b", err_late, STK);
    end
    step(1'b1, 1'b1);
    for (int p = 0; p < LOCK_CNT; p++) drive_iv(11);
    n_checks++;
    if ({locked, fault_cnt} !== {!STK, 8'd1}) begin
      n_fail++;
      $display("FAIL late_restart got locked=%b fault=%0d expected locked=%b fault=1", locked, fault_cnt, !STK);
    end
  endtask

  task automatic test_acq_robust();
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    drive_iv(5);
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 1'b0);
      n_checks++;
      if ({locked, err_early, err_late, fault_cnt} !== {3'b000, 8'd0}) begin
        n_fail++;
        $display("FAIL acq_quiet cycle=%0d got=%b fault=%0d expected=000 fault=0", c, {locked, err_early, err_late}, fault_cnt);
      end
    end
    step(1'b1, 1'b1);
    drive_iv(11);
    drive_iv(11);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL acq_idle_restart locked=%b expected=0", locked);
    end
    drive_iv(11);
    n_checks++;
    if ({locked, fault_cnt} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL acq_relock got locked=%b fault=%0d expected locked=1 fault=0", locked, fault_cnt);
    end
  endtask

  task automatic test_reset_mid();
    acquire_lock();
    for (int k = 0; k < 3; k++) begin
      drive_iv(5);
      for (int p = 0; p < LOCK_CNT; p++) drive_iv(11);
    end
    n_checks++;
    if ({locked, fault_cnt} !== {!STK, 8'd3}) begin
      n_fail++;
      $display("FAIL rstmid_pre got locked=%b fault=%0d expected locked=%b fault=3", locked, fault_cnt, !STK);
    end
    step(1'b0, 1'b1);
    n_checks++;
    if (obs_v() !== {(FCBITS+3){1'b0}}) begin
      n_fail++;
      $display("FAIL rstmid_clear got=%h expected=%h", obs_v(), {(FCBITS+3){1'b0}});
    end
    for (int p = 0; p < 3; p++) drive_iv(11);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_sig_ignored locked=%b expected=0", locked);
    end
    drive_iv(11);
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_relock locked=%b expected=1", locked);
    end
  endtask

  task automatic test_sticky();
    acquire_lock();
    drive_iv(5);
    for (int i = 1; i <= 20; i++) begin
      drive_iv(11);
      n_checks++;
      if (STK) begin
        if ({locked, err_early, fault_cnt} !== {2'b01, 8'd1}) begin
          n_fail++;
          $display("FAIL sticky period=%0d locked=%b err_early=%b fault=%0d expected 0 1 1", i, locked, err_early, fault_cnt);
        end
      end else begin
        if ({locked, err_early, fault_cnt} !== {1'(i >= LOCK_CNT), 1'b0, 8'd1}) begin
          n_fail++;
          $display("FAIL pulse_mode period=%0d locked=%b err_early=%b fault=%0d expected %b 0 1", i, locked, err_early, fault_cnt, 1'(i >= LOCK_CNT));
        end
      end
    end
  endtask

  task automatic test_saturation();
    acquire_lock();
    for (int k = 0; k < 260; k++) begin
      drive_iv(5);
      n_checks++;
      if (fault_cnt !== FCBITS'((k + 1 > 255) ? 255 : k + 1)) begin
        n_fail++;
        $display("FAIL fault_sat k=%0d fault=%0d expected=%0d", k, fault_cnt, (k + 1 > 255) ? 255 : k + 1);
      end
      for (int p = 0; p < LOCK_CNT; p++) drive_iv(11);
    end
  endtask

  task automatic test_random();
    int iv;
    step(1'b0, 1'b0);
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 99) == 0) step(1'b0, 1'($urandom_range(0, 1)));
      iv = ($urandom_range(0, 9) < 7) ? $urandom_range(10, 12) : $urandom_range(2, 16);
      for (int c = 1; c <= iv; c++) begin
        step(1'b1, c == iv);
        n_checks++;
        if (obs_v() !== exp_v()) begin
          n_fail++;
          $display("FAIL random t=%0d c=%0d got=%h expected=%h", t, c, obs_v(), exp_v());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_lock();
    test_tolerance();
    test_late();
    test_acq_robust();
    test_reset_mid();
    test_sticky();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
